serial_frame_sequencer: RTL and testbench

- Controller that sequences a free-running bit-period counter to serialize one parallel word per frame onto a single output line.
- Frame format: start bit (0), DATA_WIDTH data bits LSB first, stop bit (1).
- The counter asserts a one-cycle tick every SAMPLES_PER_BIT clocks, and the sequencer advances one bit per tick.
- Sits between a parallel producer (valid/ready handshake) and the serial link of the project.

---
 rtl/serial_frame_sequencer_pkg.sv | 15 +
 rtl/serial_frame_sequencer_bit_period_counter.sv | 32 +++
 rtl/serial_frame_sequencer.sv | 118 +++++++++++
 tb/tb_serial_frame_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_sequencer_pkg.sv
// Shared definitions for the serial frame sequencer: state encodings and
// default frame geometry.
package serial_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } seq_state_t;

    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_SAMPLES_PER_BIT = 8;

endpackage

// File: rtl/serial_frame_sequencer_bit_period_counter.sv
// Free-running bit-period counter: wraps every SAMPLES_PER_BIT clocks and
// flags the terminal count with tick.
module bit_period_counter
    import serial_frame_sequencer_pkg::*;
#(
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLES_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Explicit wrap at LAST keeps non-power-of-two periods exact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_sequencer.sv
// Serializes one parallel word per frame (start bit, LSB-first data, stop bit)
// paced by the bit-period counter; valid/ready on the parallel side.
module serial_frame_sequencer
    import serial_frame_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int SAMPLES_PER_BIT = DEFAULT_SAMPLES_PER_BIT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  bit_tick
);

    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    seq_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  serial_d, ready_d, busy_d, done_d;
    logic                  accept;
    logic                  cnt_clear;

    // The counter sits at zero while idle so the start bit gets a full period.
    assign cnt_clear = accept || (state_q == ST_IDLE);

    bit_period_counter #(
        .SAMPLES_PER_BIT(SAMPLES_PER_BIT)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clear (cnt_clear),
        .tick  (bit_tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            idx_q      <= '0;
            serial_out <= 1'b1;
            data_ready <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            serial_out <= serial_d;
            data_ready <= ready_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so every line level is registered.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        serial_d = serial_out;
        ready_d  = data_ready;
        busy_d   = busy;
        done_d   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b1;
                busy_d   = 1'b0;
                serial_d = 1'b1;
                if (data_valid && data_ready) begin
                    accept   = 1'b1;
                    shift_d  = data_in;
                    idx_d    = '0;
                    state_d  = ST_START;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    serial_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
                    end else begin
                        serial_d = shift_d[0];
                    end
                end
            end
            ST_STOP: begin
                serial_d = 1'b1;
                if (bit_tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed bench for serial_frame_sequencer: default geometry instance plus a
// SAMPLES_PER_BIT=2 instance, both checked against hand-derived frames.
module tb_serial_frame_sequencer;

    logic       clock;
    logic       reset;

    logic [7:0] din1, din2;
    logic       vld1, vld2;
    logic       rdy1, rdy2, so1, so2, busy1, busy2, done1, done2, tick1, tick2;

    int         sel_q;
    logic       o_rdy, o_so, o_busy, o_done, o_tick;

    int         n_tests;
    int         n_fail;

    serial_frame_sequencer #(.DATA_WIDTH(8), .SAMPLES_PER_BIT(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (din1),
        .data_valid (vld1),
        .data_ready (rdy1),
        .serial_out (so1),
        .busy       (busy1),
        .frame_done (done1),
        .bit_tick   (tick1)
    );

    serial_frame_sequencer #(.DATA_WIDTH(8), .SAMPLES_PER_BIT(2)) dut2 (
        .clock      (clock),
        .reset      (reset),
        .data_in    (din2),
        .data_valid (vld2),
        .data_ready (rdy2),
        .serial_out (so2),
        .busy       (busy2),
        .frame_done (done2),
        .bit_tick   (tick2)
    );

    assign o_rdy  = (sel_q != 0) ? rdy2  : rdy1;
    assign o_so   = (sel_q != 0) ? so2   : so1;
    assign o_busy = (sel_q != 0) ? busy2 : busy1;
    assign o_done = (sel_q != 0) ? done2 : done1;
    assign o_tick = (sel_q != 0) ? tick2 : tick1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin
            vld2 = v;
            din2 = d;
        end else begin
            vld1 = v;
            din1 = d;
        end
    endtask

    // Presents word, then samples every cycle of the frame from the accept edge on.
    task automatic run_frame(input int sel, input logic [7:0] word, input bit keep_valid,
                             input logic [7:0] next_word, input int pulse_at, input string tag);
        int         spb;
        int         slot;
        int         n_busy;
        int         n_done;
        int         n_rdy;
        int         tick_err;
        logic [7:0] sv;
        logic [7:0] expv;
        logic       bitv;
        spb      = (sel != 0) ? 2 : 8;
        sel_q    = sel;
        n_busy   = 0;
        n_done   = 0;
        n_rdy    = 0;
        tick_err = 0;
        sv       = 8'h00;
        drive(sel, 1'b1, word);
        @(negedge clock);
        check({tag, " accept busy"}, 32'(o_busy), 1);
        check({tag, " accept ready"}, 32'(o_rdy), 0);
        if (keep_valid) drive(sel, 1'b1, next_word);
        else            drive(sel, 1'b0, word);
        for (int i = 0; i < 10 * spb; i++) begin
            if (i > 0) @(negedge clock);
            if (o_busy) n_busy++;
            if (o_done) n_done++;
            if (o_rdy)  n_rdy++;
            if (o_tick !== ((i % spb) == (spb - 1))) tick_err++;
            if ((i % spb) == 0) sv = 8'h00;
            sv[3'(i % spb)] = o_so;
            if ((i % spb) == (spb - 1)) begin
                slot = i / spb;
                if (slot == 0)      bitv = 1'b0;
                else if (slot == 9) bitv = 1'b1;
                else                bitv = word[3'(slot - 1)];
                expv = bitv ? 8'((1 << spb) - 1) : 8'h00;
                check($sformatf("%s slot%0d", tag, slot), 32'(sv), 32'(expv));
            end
            if (i == pulse_at)                       drive(sel, 1'b1, 8'h3C);
            else if (pulse_at >= 0 && i == pulse_at + 1) drive(sel, 1'b0, 8'h3C);
        end
        @(negedge clock);
        check({tag, " done pulse"}, 32'(o_done), 1);
        check({tag, " busy after"}, 32'(o_busy), 0);
        check({tag, " ready after"}, 32'(o_rdy), 1);
        check({tag, " line idle"}, 32'(o_so), 1);
        check({tag, " busy cycles"}, n_busy, 10 * spb);
        check({tag, " early done"}, n_done, 0);
        check({tag, " ready while busy"}, n_rdy, 0);
        check({tag, " tick cadence errs"}, tick_err, 0);
    endtask

    initial begin
        int n_done_rst;
        n_tests = 0;
        n_fail  = 0;
        sel_q   = 0;
        reset   = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);

        repeat (2) @(negedge clock);
        check("rst serial_out", 32'(so1), 1);
        check("rst data_ready", 32'(rdy1), 1);
        check("rst busy", 32'(busy1), 0);
        check("rst frame_done", 32'(done1), 0);
        check("rst bit_tick", 32'(tick1), 0);
        check("rst2 bit_tick", 32'(tick2), 0);
        reset = 1'b1;

        run_frame(0, 8'hA5, 1'b0, 8'h00, -1, "a5");
        @(negedge clock);

        run_frame(0, 8'h00, 1'b1, 8'hFF, -1, "b2b 00");
        run_frame(0, 8'hFF, 1'b0, 8'h00, -1, "b2b ff");
        @(negedge clock);

        run_frame(0, 8'h81, 1'b0, 8'h00, 20, "81 ignore");
        repeat (3) @(negedge clock);
        check("81 no second frame busy", 32'(busy1), 0);
        check("81 no second frame line", 32'(so1), 1);

        sel_q      = 0;
        n_done_rst = 0;
        drive(0, 1'b1, 8'hC3);
        @(negedge clock);
        drive(0, 1'b0, 8'hC3);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            if (done1) n_done_rst++;
        end
        check("rst mid pre line", 32'(so1), 0);
        reset = 1'b0;
        #1;
        check("rst mid line", 32'(so1), 1);
        check("rst mid busy", 32'(busy1), 0);
        check("rst mid ready", 32'(rdy1), 1);
        check("rst mid done", 32'(done1), 0);
        repeat (2) begin
            @(negedge clock);
            if (done1) n_done_rst++;
        end
        check("rst mid no done", n_done_rst, 0);
        reset = 1'b1;
        run_frame(0, 8'h5A, 1'b0, 8'h00, -1, "5a after rst");

        run_frame(1, 8'h01, 1'b0, 8'h00, -1, "spb2 01");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
